apb_arbiter: RTL and testbench



---
 rtl/apb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_apb_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester round-robin arbiter in front of one APB master port.
// Transfers run IDLE -> SETUP -> ACCESS (wait states) -> IDLE with a DONE pulse.
// Ports:
//   HCLK, HRESET          clock, async active-high reset
//   REQ/REQ_ADDR/REQ_WRITE/REQ_WDATA  per-requester request bundle (req 0 in low slice)
//   DONE/ERR/RDATA        per-requester completion pulse, status, shared read data
//   GRANT_ID              requester currently owning the bus
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA/PRDATA/PREADY/PSLVERR  APB master side
// Optional: define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [1:0]              REQ,
  input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [1:0]              REQ_WRITE,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]              DONE,
  output logic [1:0]              ERR,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    GRANT_ID,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_done;
  logic [1:0]            r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_gid;
  logic                  r_last;
  logic                  r_psel;
  logic                  r_penable;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;

  logic [1:0]            w_elig;
  logic                  w_win;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [1:0]            w_gid_oh;
  logic                  w_tmo_hit;
  logic                  w_fin;

  // A requester whose DONE is high this cycle is still holding REQ
  // from the finished transfer; mask it to avoid a duplicate grant.
  assign w_elig = REQ & ~r_done;

  // On a tie the requester not granted last wins.
  assign w_win = (w_elig == 2'b11) ? ~r_last : w_elig[1];

  assign w_addr  = w_win ? REQ_ADDR[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                         : REQ_ADDR[ADDR_WIDTH-1:0];
  assign w_write = w_win ? REQ_WRITE[1] : REQ_WRITE[0];
  assign w_wdata = w_win ? REQ_WDATA[2*DATA_WIDTH-1 -: DATA_WIDTH]
                         : REQ_WDATA[DATA_WIDTH-1:0];

  assign w_gid_oh = r_gid ? 2'b10 : 2'b01;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo;

  // Counts ACCESS cycles with PREADY low; the hit fires on the
  // TIMEOUT_CYCLES-th such cycle so the abort lands on that edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_tmo <= '0;
    end else if (r_state == SETUP) begin
      r_tmo <= '0;
    end else if (r_state == ACCESS && !PREADY) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_tmo_hit = (r_state == ACCESS) && !PREADY
                  && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;

  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo_hit    = 1'b0;
`endif

  assign w_fin = PREADY | w_tmo_hit;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= IDLE;
      r_done    <= '0;
      r_err     <= '0;
      r_rdata   <= '0;
      r_gid     <= 1'b0;
      r_last    <= 1'b1;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_gid    <= w_win;
            r_paddr  <= w_addr;
            r_pwrite <= w_write;
            r_pwdata <= w_wdata;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_fin) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= w_gid_oh;
            r_last    <= r_gid;
            r_state   <= IDLE;
            if (PREADY) begin
              r_err <= w_gid_oh & {2{PSLVERR}};
              if (!r_pwrite) begin
                r_rdata <= PRDATA;
              end
            end else begin
              // Timed out: report error, never forward stale bus data.
              r_err   <= w_gid_oh;
              r_rdata <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign DONE     = r_done;
  assign ERR      = r_err;
  assign RDATA    = r_rdata;
  assign GRANT_ID = r_gid;
  assign PSEL     = r_psel;
  assign PENABLE  = r_penable;
  assign PADDR    = r_paddr;
  assign PWRITE   = r_pwrite;
  assign PWDATA   = r_pwdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: random two-requester traffic against a transaction-level
// model, a memory-backed APB slave and a DONE-driven scoreboard.
module tb_apb_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [1:0]    REQ;
  logic [63:0]   REQ_ADDR;
  logic [1:0]    REQ_WRITE;
  logic [63:0]   REQ_WDATA;
  logic [1:0]    DONE;
  logic [1:0]    ERR;
  logic [31:0]   RDATA;
  logic          GRANT_ID;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PADDR;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .REQ       (REQ),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WRITE (REQ_WRITE),
    .REQ_WDATA (REQ_WDATA),
    .DONE      (DONE),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .GRANT_ID  (GRANT_ID),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  idx;
    logic [31:0] wdata;
  } dir_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        sb0[$];
  txn_t        sb1[$];
  dir_t        dq0[$];
  dir_t        dq1[$];
  int          wait_q[$];
  txn_t        txn[2];
  txn_t        g;
  logic [1:0]  busy;
  logic [1:0]  p_req;
  logic [1:0]  p_done;
  logic        p_ready;
  int          m_phase;
  logic        m_last;
  logic        m_cur;
  logic [31:0] m_rdata;
`ifdef APB_ARB_TIMEOUT_EN
  int          m_wait;
`endif
  int          s_wait;
  logic        stuck;
  logic        rand_en;
  logic        first_chk;
  logic [31:0] ref_mem[0:127];
  logic [31:0] slv_mem[0:127];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input int i);
    dir_t       d;
    txn_t       t;
    logic [6:0] mi;
    if (i == 0 && dq0.size() > 0) d = dq0.pop_front();
    else if (i == 1 && dq1.size() > 0) d = dq1.pop_front();
    else begin
      d.wr    = 1'($urandom_range(0, 1));
      d.idx   = 4'($urandom_range(0, 15));
      d.wdata = $urandom;
    end
    t.wr    = d.wr;
    t.wdata = d.wdata;
    t.addr  = {23'd0, 1'(i), 2'b00, d.idx, 2'b00};
    mi      = t.addr[8:2];
    t.err   = stuck || (d.idx == 4'hF);
    t.rdata = '0;
    if (!t.wr && !stuck) t.rdata = ref_mem[mi];
    if (t.wr && !t.err) ref_mem[mi] = t.wdata;
    txn[i]       = t;
    busy[i]      = 1'b1;
    REQ[i]       = 1'b1;
    REQ_WRITE[i] = t.wr;
    if (i == 0) begin
      REQ_ADDR[31:0]  = t.addr;
      REQ_WDATA[31:0] = t.wdata;
      sb0.push_back(t);
    end else begin
      REQ_ADDR[63:32]  = t.addr;
      REQ_WDATA[63:32] = t.wdata;
      sb1.push_back(t);
    end
  endtask

  task automatic step();
    logic [1:0] elig;
    logic [1:0] exp_done;
    logic       ps;
    logic       pe;
    logic       fin;
    logic [6:0] sidx;
    logic       se;
    ps = PSEL;
    pe = PENABLE;
    if (HRESET) begin
      chk("reset_ctrl", 64'({ps, pe, PWRITE, GRANT_ID, DONE, ERR}), 64'd0);
      chk("reset_paddr", 64'(PADDR), 64'd0);
      chk("reset_data", {PWDATA, RDATA}, 64'd0);
      return;
    end
    exp_done = 2'b00;
    case (m_phase)
      0: begin
        elig = p_req & ~p_done;
        if (elig != 2'b00) begin
          m_cur   = (elig == 2'b11) ? ~m_last : elig[1];
          g       = txn[m_cur];
          m_phase = 1;
          if (first_chk) begin
            chk("first_grant_after_reset", 64'(GRANT_ID), 64'd0);
            first_chk = 1'b0;
          end
          chk("setup_phase", 64'({ps, pe}), 64'b10);
          chk("grant_id", 64'(GRANT_ID), 64'(m_cur));
        end else begin
          chk("idle_phase", 64'({ps, pe}), 64'b00);
        end
      end
      1: begin
        m_phase = 2;
`ifdef APB_ARB_TIMEOUT_EN
        m_wait  = 0;
`endif
        chk("access_phase", 64'({ps, pe}), 64'b11);
        chk("grant_id_access", 64'(GRANT_ID), 64'(m_cur));
      end
      default: begin
        fin = p_ready;
`ifdef APB_ARB_TIMEOUT_EN
        if (!p_ready) begin
          m_wait++;
          fin = (m_wait == TMO);
        end
`endif
        if (fin) begin
          m_phase  = 0;
          exp_done = m_cur ? 2'b10 : 2'b01;
          m_last   = m_cur;
          if (!g.wr || !p_ready) m_rdata = g.rdata;
          chk("end_phase", 64'({ps, pe}), 64'b00);
        end else begin
          chk("access_hold", 64'({ps, pe}), 64'b11);
          chk("grant_id_hold", 64'(GRANT_ID), 64'(m_cur));
        end
      end
    endcase
    chk("paddr", 64'(PADDR), 64'(g.addr));
    chk("pwrite_pwdata", 64'({PWRITE, PWDATA}), 64'({g.wr, g.wdata}));
    chk("rdata_hold", 64'(RDATA), 64'(m_rdata));
    chk("done", 64'(DONE), 64'(exp_done));

    for (int i = 0; i < 2; i++) begin
      if (DONE[i]) busy[i] = 1'b0;
      if (!busy[i]) begin
        if ((i == 0 && dq0.size() > 0) || (i == 1 && dq1.size() > 0)
            || (rand_en && $urandom_range(0, 9) < 4)) issue(i);
        else REQ[i] = 1'b0;
      end
    end

    if (ps && pe) begin
      if (!stuck && s_wait == 0) begin
        sidx    = PADDR[8:2];
        se      = (PADDR[5:2] == 4'hF);
        PREADY  = 1'b1;
        PSLVERR = se;
        PRDATA  = slv_mem[sidx];
        if (PWRITE && !se) slv_mem[sidx] = PWDATA;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
        if (s_wait > 0) s_wait--;
      end
    end else begin
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
    end
    if (ps && !pe) begin
      if (wait_q.size() > 0) s_wait = wait_q.pop_front();
      else s_wait = $urandom_range(0, 3);
    end

    p_req   = REQ;
    p_done  = DONE;
    p_ready = PREADY;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge HCLK);
      step();
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((busy != 2'b00 || dq0.size() > 0 || dq1.size() > 0
            || m_phase != 0) && k < budget) begin
      @(negedge HCLK);
      step();
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL drain_timeout got %0d cycles want < %0d", k, budget);
    end
  endtask

  task automatic flush_model();
    sb0.delete();
    sb1.delete();
    dq0.delete();
    dq1.delete();
    wait_q.delete();
    busy      = 2'b00;
    REQ       = 2'b00;
    m_phase   = 0;
    m_last    = 1'b1;
    m_cur     = 1'b0;
    g         = '0;
    m_rdata   = '0;
    p_req     = 2'b00;
    p_done    = 2'b00;
    p_ready   = 1'b0;
    s_wait    = 0;
  endtask

  // Scoreboard: consumes one expectation per DONE pulse.
  always @(negedge HCLK) begin
    txn_t e;
    if (!HRESET && DONE != 2'b00) begin
      for (int i = 0; i < 2; i++) begin
        if (DONE[i]) begin
          if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected req %0d got DONE want none", i);
          end else begin
            e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("sb_err", 64'(ERR[i]), 64'(e.err));
            if (!e.wr) chk("sb_rdata", 64'(RDATA), 64'(e.rdata));
          end
        end
      end
    end
  end

  initial begin
    HRESET    = 1'b1;
    REQ_ADDR  = '0;
    REQ_WRITE = '0;
    REQ_WDATA = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    stuck     = 1'b0;
    rand_en   = 1'b0;
    first_chk = 1'b0;
    txn[0]    = '0;
    txn[1]    = '0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = {16'hC0DE, 16'(i)};
      slv_mem[i] = ref_mem[i];
    end
    flush_model();

    run(3);
    #2 HRESET = 1'b0;

    dq0.push_back('{1'b1, 4'd4, 32'hA5A5A5A5});
    wait_q.push_back(0);
    drain(40);

    dq0.push_back('{1'b1, 4'd5, 32'hDEADBEEF});
    dq0.push_back('{1'b0, 4'd5, 32'h0});
    wait_q.push_back(0);
    wait_q.push_back(4);
    drain(60);

    dq1.push_back('{1'b0, 4'd15, 32'h0});
    dq1.push_back('{1'b0, 4'd3, 32'h0});
    drain(60);

    for (int i = 0; i < 3; i++) begin
      dq0.push_back('{1'(i), 4'(i + 6), $urandom});
      dq1.push_back('{1'(i + 1), 4'(i + 9), $urandom});
    end
    drain(200);

    rand_en = 1'b1;
    run(1500);
    rand_en = 1'b0;
    drain(200);

    dq0.push_back('{1'b0, 4'd2, 32'h0});
    wait_q.push_back(8);
    run(5);
    chk("in_access_before_reset", 64'({PSEL, PENABLE}), 64'b11);
    #2 HRESET = 1'b1;
    #1 chk("reset_async", 64'({PSEL, PENABLE, DONE}), 64'd0);
    flush_model();
    run(2);
    #2 HRESET = 1'b0;
    first_chk = 1'b1;
    dq0.push_back('{1'b0, 4'd1, 32'h0});
    dq1.push_back('{1'b1, 4'd1, 32'h12345678});
    drain(60);

`ifdef APB_ARB_TIMEOUT_EN
    stuck = 1'b1;
    dq0.push_back('{1'b0, 4'd7, 32'h0});
    drain(TMO + 20);
    stuck = 1'b0;
`endif

    run(2);
    chk("sb_empty", 64'(sb0.size() + sb1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
